// File: rtl/id_issue_reg.sv
// Dual-lane ID->EX issue register: splits intra-packet RAW pairs over two
// cycles, registers issued lanes into EX under valid/allowin, counts stalls.
module id_issue_reg #(
  parameter int UOP_W  = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic              id_line1_valid_i,
  input  logic              id_line2_valid_i,
  input  logic [UOP_W-1:0]  id_line1_uop_i,
  input  logic [UOP_W-1:0]  id_line2_uop_i,
  input  logic              id_line1_we_i,
  input  logic [4:0]        id_line1_waddr_i,
  input  logic              id_line2_we_i,
  input  logic [4:0]        id_line2_waddr_i,
  input  logic              id_line2_re1_i,
  input  logic              id_line2_re2_i,
  input  logic [4:0]        id_line2_raddr1_i,
  input  logic [4:0]        id_line2_raddr2_i,
  input  logic              line1_regs_read_ready_i,
  input  logic              line2_regs_read_ready_i,
  input  logic [DATA_W-1:0] line1_rdata1_i,
  input  logic [DATA_W-1:0] line1_rdata2_i,
  input  logic [DATA_W-1:0] line2_rdata1_i,
  input  logic [DATA_W-1:0] line2_rdata2_i,
  input  logic              ex_allowin_i,
  output logic              id_allowin_o,
  output logic              ex_line1_valid_o,
  output logic              ex_line2_valid_o,
  output logic [UOP_W-1:0]  ex_line1_uop_o,
  output logic [UOP_W-1:0]  ex_line2_uop_o,
  output logic [DATA_W-1:0] ex_line1_src1_o,
  output logic [DATA_W-1:0] ex_line1_src2_o,
  output logic [DATA_W-1:0] ex_line2_src1_o,
  output logic [DATA_W-1:0] ex_line2_src2_o,
  output logic              ex_line1_we_o,
  output logic              ex_line2_we_o,
  output logic [4:0]        ex_line1_waddr_o,
  output logic [4:0]        ex_line2_waddr_o,
  output logic              split_active_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic {S_PAIR = 1'b0, S_SECOND = 1'b1} state_t;

  state_t state_p0, state_nxt;

  logic intra, rdy1, rdy2;
  logic pair_fire, first_fire, second_fire;
  logic stall;

  logic                     vld1_p1, vld2_p1;
  logic [UOP_W-1:0]         uop1_p1, uop2_p1;
  logic signed [DATA_W-1:0] src11_p1, src12_p1, src21_p1, src22_p1;
  logic                     we1_p1, we2_p1;
  logic [4:0]               waddr1_p1, waddr2_p1;
  logic [CNT_W-1:0]         stall_cnt_p1;

  // ---- stage p0: hazard detection, fire decisions, FSM next state ----
  always_comb begin
    intra = id_line1_valid_i & id_line2_valid_i & id_line1_we_i &
            (id_line1_waddr_i != 5'd0) &
            ((id_line2_re1_i & (id_line2_raddr1_i == id_line1_waddr_i)) |
             (id_line2_re2_i & (id_line2_raddr2_i == id_line1_waddr_i)));
    rdy1 = ~id_line1_valid_i | line1_regs_read_ready_i;
    rdy2 = ~id_line2_valid_i | line2_regs_read_ready_i;

    pair_fire   = 1'b0;
    first_fire  = 1'b0;
    second_fire = 1'b0;
    state_nxt   = state_p0;
    id_allowin_o = 1'b0;

    case (state_p0)
      S_PAIR: begin
        pair_fire  = ~flush_i & id_valid_i & ~intra & rdy1 & rdy2 & ex_allowin_i;
        first_fire = ~flush_i & id_valid_i & intra & line1_regs_read_ready_i &
                     ex_allowin_i;
        id_allowin_o = ~id_valid_i | pair_fire;
        if (first_fire) state_nxt = S_SECOND;
      end
      S_SECOND: begin
        // ID holds the packet; lane2 now depends on lane1 in EX via forwarding
        second_fire  = ~flush_i & line2_regs_read_ready_i & ex_allowin_i;
        id_allowin_o = second_fire;
        if (second_fire) state_nxt = S_PAIR;
      end
      default: state_nxt = S_PAIR;
    endcase

    if (flush_i) state_nxt = S_PAIR;
    if (flush_i | rst) id_allowin_o = 1'b1;

    stall = id_valid_i & ~flush_i & ~(pair_fire | first_fire | second_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) state_p0 <= S_PAIR;
    else     state_p0 <= state_nxt;
  end

  // ---- stage p1: EX issue register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld1_p1   <= 1'b0;
      vld2_p1   <= 1'b0;
      uop1_p1   <= '0;
      uop2_p1   <= '0;
      src11_p1  <= '0;
      src12_p1  <= '0;
      src21_p1  <= '0;
      src22_p1  <= '0;
      we1_p1    <= 1'b0;
      we2_p1    <= 1'b0;
      waddr1_p1 <= '0;
      waddr2_p1 <= '0;
    end else if (flush_i) begin
      vld1_p1 <= 1'b0;
      vld2_p1 <= 1'b0;
    end else if (ex_allowin_i) begin
      vld1_p1   <= (pair_fire & id_line1_valid_i) | first_fire;
      vld2_p1   <= (pair_fire & id_line2_valid_i) | second_fire;
      uop1_p1   <= id_line1_uop_i;
      uop2_p1   <= id_line2_uop_i;
      src11_p1  <= signed'(line1_rdata1_i);
      src12_p1  <= signed'(line1_rdata2_i);
      src21_p1  <= signed'(line2_rdata1_i);
      src22_p1  <= signed'(line2_rdata2_i);
      we1_p1    <= id_line1_we_i;
      we2_p1    <= id_line2_we_i;
      waddr1_p1 <= id_line1_waddr_i;
      waddr2_p1 <= id_line2_waddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)        stall_cnt_p1 <= '0;
    else if (stall) stall_cnt_p1 <= stall_cnt_p1 + CNT_W'(1);
  end

  assign ex_line1_valid_o = vld1_p1;
  assign ex_line2_valid_o = vld2_p1;
  assign ex_line1_uop_o   = uop1_p1;
  assign ex_line2_uop_o   = uop2_p1;
  assign ex_line1_src1_o  = src11_p1;
  assign ex_line1_src2_o  = src12_p1;
  assign ex_line2_src1_o  = src21_p1;
  assign ex_line2_src2_o  = src22_p1;
  assign ex_line1_we_o    = we1_p1;
  assign ex_line2_we_o    = we2_p1;
  assign ex_line1_waddr_o = waddr1_p1;
  assign ex_line2_waddr_o = waddr2_p1;
  assign split_active_o   = (state_p0 == S_SECOND);
  assign stall_cnt_o      = stall_cnt_p1;

endmodule

// File: tb/tb_id_issue_reg.sv
// Scoreboard bench for id_issue_reg: a behavioural model predicts the EX
// register and counter per cycle; predictions are queued and popped after the edge.
module tb_id_issue_reg;
  localparam int UOP_W = 64, DATA_W = 32, CNT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, id_valid, l1v, l2v, we1, we2, re1, re2, rr1, rr2, exa;
  logic [UOP_W-1:0]  u1, u2;
  logic [4:0]        wa1, wa2, ra1, ra2;
  logic [DATA_W-1:0] d11, d12, d21, d22;

  logic              id_allowin, o_v1, o_v2, o_we1, o_we2, o_split;
  logic [UOP_W-1:0]  o_u1, o_u2;
  logic [DATA_W-1:0] o_s11, o_s12, o_s21, o_s22;
  logic [4:0]        o_wa1, o_wa2;
  logic [CNT_W-1:0]  o_cnt;

  id_issue_reg #(.UOP_W(UOP_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .id_valid_i(id_valid),
    .id_line1_valid_i(l1v), .id_line2_valid_i(l2v),
    .id_line1_uop_i(u1), .id_line2_uop_i(u2),
    .id_line1_we_i(we1), .id_line1_waddr_i(wa1),
    .id_line2_we_i(we2), .id_line2_waddr_i(wa2),
    .id_line2_re1_i(re1), .id_line2_re2_i(re2),
    .id_line2_raddr1_i(ra1), .id_line2_raddr2_i(ra2),
    .line1_regs_read_ready_i(rr1), .line2_regs_read_ready_i(rr2),
    .line1_rdata1_i(d11), .line1_rdata2_i(d12),
    .line2_rdata1_i(d21), .line2_rdata2_i(d22),
    .ex_allowin_i(exa), .id_allowin_o(id_allowin),
    .ex_line1_valid_o(o_v1), .ex_line2_valid_o(o_v2),
    .ex_line1_uop_o(o_u1), .ex_line2_uop_o(o_u2),
    .ex_line1_src1_o(o_s11), .ex_line1_src2_o(o_s12),
    .ex_line2_src1_o(o_s21), .ex_line2_src2_o(o_s22),
    .ex_line1_we_o(o_we1), .ex_line2_we_o(o_we2),
    .ex_line1_waddr_o(o_wa1), .ex_line2_waddr_o(o_wa2),
    .split_active_o(o_split), .stall_cnt_o(o_cnt)
  );

  typedef struct {
    logic v1, v2, we1, we2, split, full;
    logic [UOP_W-1:0] u1, u2;
    logic [DATA_W-1:0] s11, s12, s21, s22;
    logic [4:0] wa1, wa2;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    logic intra, rdy1, rdy2, pf, ff, sf, ea;
    #1;
    intra = l1v & l2v & we1 & (wa1 != 5'd0) &
            ((re1 & (ra1 == wa1)) | (re2 & (ra2 == wa1)));
    rdy1 = ~l1v | rr1;
    rdy2 = ~l2v | rr2;
    pf = ~m.split & ~flush & id_valid & ~intra & rdy1 & rdy2 & exa;
    ff = ~m.split & ~flush & id_valid & intra & rr1 & exa;
    sf =  m.split & ~flush & rr2 & exa;
    ea = rst | flush | (m.split ? sf : (~id_valid | pf));
    check_eq("id_allowin", id_allowin, ea);
    if (rst) begin
      m = '{default: '0};
      m.full = 1'b1;
    end else begin
      m.full = 1'b0;
      if (id_valid & ~flush & ~(pf | ff | sf)) m.cnt = m.cnt + 1'b1;
      if (flush) begin
        m.v1 = 1'b0; m.v2 = 1'b0; m.split = 1'b0;
      end else if (exa) begin
        m.v1 = (pf & l1v) | ff;
        m.v2 = (pf & l2v) | sf;
        m.u1 = u1; m.u2 = u2;
        m.s11 = d11; m.s12 = d12; m.s21 = d21; m.s22 = d22;
        m.we1 = we1; m.we2 = we2; m.wa1 = wa1; m.wa2 = wa2;
        if (ff) m.split = 1'b1;
        else if (sf) m.split = 1'b0;
      end
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_eq("ex_line1_valid", o_v1, e.v1);
    check_eq("ex_line2_valid", o_v2, e.v2);
    check_eq("split_active", o_split, e.split);
    check_eq("stall_cnt", o_cnt, e.cnt);
    if (e.v1 || e.full) begin
      check_eq("ex_line1_uop", o_u1, e.u1);
      check_eq("ex_line1_src1", o_s11, e.s11);
      check_eq("ex_line1_src2", o_s12, e.s12);
      check_eq("ex_line1_we", o_we1, e.we1);
      check_eq("ex_line1_waddr", o_wa1, e.wa1);
    end
    if (e.v2 || e.full) begin
      check_eq("ex_line2_uop", o_u2, e.u2);
      check_eq("ex_line2_src1", o_s21, e.s21);
      check_eq("ex_line2_src2", o_s22, e.s22);
      check_eq("ex_line2_we", o_we2, e.we2);
      check_eq("ex_line2_waddr", o_wa2, e.wa2);
    end
  endtask

  // Full two-lane packet, both ready, EX accepting; callers tweak afterwards.
  task automatic pkt(input logic [4:0] w1, input logic rd1, input logic [4:0] r1a,
                     input logic rd2, input logic [4:0] r2a);
    rst = 1'b0; flush = 1'b0; id_valid = 1'b1; l1v = 1'b1; l2v = 1'b1;
    we1 = 1'b1; wa1 = w1; we2 = 1'b1; wa2 = 5'd9;
    re1 = rd1; ra1 = r1a; re2 = rd2; ra2 = r2a;
    rr1 = 1'b1; rr2 = 1'b1; exa = 1'b1;
    u1 = {$urandom, $urandom}; u2 = {$urandom, $urandom};
    d11 = $urandom; d12 = $urandom; d21 = $urandom; d22 = $urandom;
  endtask

  initial begin
    m = '{default: '0};
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; l1v = 1'b0; l2v = 1'b0;
    we1 = 1'b0; we2 = 1'b0; re1 = 1'b0; re2 = 1'b0; rr1 = 1'b0; rr2 = 1'b0;
    exa = 1'b0; u1 = '0; u2 = '0; wa1 = '0; wa2 = '0; ra1 = '0; ra2 = '0;
    d11 = '0; d12 = '0; d21 = '0; d22 = '0;
    step(); step();

    // independent pair
    pkt(5'd5, 1'b1, 5'd6, 1'b1, 5'd7); step();
    // intra RAW split over two cycles
    pkt(5'd3, 1'b1, 5'd3, 1'b0, 5'd0); step(); step();
    // r0 destination never splits
    pkt(5'd0, 1'b1, 5'd0, 1'b1, 5'd0); step();
    // load-use stall then issue
    pkt(5'd5, 1'b1, 5'd6, 1'b1, 5'd7); rr2 = 1'b0;
    step(); step(); step(); rr2 = 1'b1; step();
    // backpressure holding uop 0xA5
    pkt(5'd5, 1'b1, 5'd6, 1'b1, 5'd7); u1 = 64'hA5; step();
    pkt(5'd8, 1'b1, 5'd6, 1'b1, 5'd7); exa = 1'b0; step(); step();
    exa = 1'b1; step();
    // flush while in the second half of a split
    pkt(5'd4, 1'b0, 5'd0, 1'b1, 5'd4); step();
    flush = 1'b1; step(); flush = 1'b0; step();
    // reset in the middle of a split
    pkt(5'd4, 1'b1, 5'd4, 1'b0, 5'd0); step();
    rst = 1'b1; step(); rst = 1'b0;
    // lane2-only packet carrying a would-be hazard pattern
    pkt(5'd2, 1'b1, 5'd2, 1'b0, 5'd0); l1v = 1'b0; step();
    // counter wrap with a long stall
    pkt(5'd5, 1'b1, 5'd6, 1'b1, 5'd7); rr1 = 1'b0;
    for (int i = 0; i < 18; i++) step();
    rr1 = 1'b1; step();
    // idle
    id_valid = 1'b0; step();

    for (int i = 0; i < 80; i++) begin
      pkt(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
          1'($urandom), 5'($urandom_range(0, 3)));
      id_valid = ($urandom_range(0, 7) != 0);
      l1v = ($urandom_range(0, 5) != 0);
      l2v = ($urandom_range(0, 5) != 0);
      we1 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      rr2 = ($urandom_range(0, 3) != 0);
      exa = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
